// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter next-address sequencer.
package pc_seq_pkg;

  localparam int PC_W      = 64;
  localparam int INSN_SIZE = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with synchronous clear that holds at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the PC register: advance, hold, or redirect,
// plus IF valid and pipeline flush generation.
//
//   state | meaning
//   BOOT  | one cycle after reset, presents RESET_VECTOR
//   RUN   | normal fetch, pc_q + 4
//   STALL | hazard hold, pc_next = pc_q while stall is high
//   FLUSH | squash cycles after a redirect, fetch marked invalid
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 64'h0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_q,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] pc_next,
  output logic            if_valid,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     redirect_cnt
);

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam state_t     REDIR_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic            accept_redir;
  logic            stall_hold;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redir_tgt;

  assign pc_inc    = pc_q + PC_W'(INSN_SIZE);
  assign redir_tgt = {redirect_target[PC_W-1:2], 2'b00};

  always_comb begin
    pc_next      = pc_inc;
    if_valid     = 1'b0;
    flush_o      = 1'b0;
    accept_redir = 1'b0;
    stall_hold   = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    case (state_q)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = RUN;
      end
      RUN, STALL: begin
        if_valid = 1'b1;
        if (redirect_valid) begin
          accept_redir = 1'b1;
          pc_next      = redir_tgt;
          flush_o      = 1'b1;
          fcnt_d       = FLUSH_LOAD;
          state_d      = REDIR_STATE;
        end else if (stall) begin
          pc_next    = pc_q;
          stall_hold = 1'b1;
          state_d    = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (redirect_valid) begin
          accept_redir = 1'b1;
          pc_next      = redir_tgt;
          fcnt_d       = FLUSH_LOAD;
        end else begin
          // Counter holds the FLUSH cycles still owed; the redirect cycle
          // itself already supplied the first flush cycle.
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fcnt_q     <= '0;
      misalign_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      misalign_o <= misalign_o | (accept_redir & (|redirect_target[1:0]));
    end
  end

  sat_counter32 u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (stall_hold),
    .cnt (stall_cnt)
  );

  sat_counter32 u_redirect_cnt (
    .clk (clk),
    .clr (reset),
    .en  (accept_redir),
    .cnt (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with a behavioural PC register.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_q = 64'h0;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] pc_next;
  logic        if_valid;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] stall_cnt;
  logic [31:0] redirect_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(
    .RESET_VECTOR (64'h400),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_q            (pc_q),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_next),
    .if_valid        (if_valid),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o),
    .stall_cnt       (stall_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  always #5 clk = ~clk;

  // PC register the sequencer feeds; resets to 0 on its own.
  always @(posedge clk) begin
    if (reset) pc_q <= 64'h0;
    else       pc_q <= pc_next;
  end

  typedef struct {
    logic        stall;
    logic        rv;
    logic [63:0] tgt;
    logic [63:0] pn;
    logic        ifv;
    logic        fl;
    logic [31:0] sc;
    logic [31:0] rc;
    logic        mis;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic s, input logic r, input logic [63:0] t,
                     input logic [63:0] pn, input logic ifv, input logic fl,
                     input logic [31:0] sc, input logic [31:0] rc, input logic mis);
    vec_t v;
    v.stall = s; v.rv = r; v.tgt = t; v.pn = pn; v.ifv = ifv; v.fl = fl;
    v.sc = sc; v.rc = rc; v.mis = mis;
    vec.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;

    //   stall rv  target                  pc_next                 ifv fl sc rc mis
    add(1, 1, 64'h7777,               64'h400,                0, 0, 0, 0, 0); // BOOT ignores inputs
    add(0, 0, 64'h0,                  64'h404,                1, 0, 0, 0, 0);
    add(0, 0, 64'h0,                  64'h408,                1, 0, 0, 0, 0);
    add(0, 0, 64'h0,                  64'h40C,                1, 0, 0, 0, 0);
    add(1, 0, 64'h0,                  64'h40C,                1, 0, 1, 0, 0);
    add(1, 0, 64'h0,                  64'h40C,                1, 0, 2, 0, 0);
    add(1, 0, 64'h0,                  64'h40C,                1, 0, 3, 0, 0);
    add(0, 0, 64'h0,                  64'h410,                1, 0, 3, 0, 0);
    add(0, 0, 64'h0,                  64'h414,                1, 0, 3, 0, 0);
    add(0, 0, 64'h0,                  64'h418,                1, 0, 3, 0, 0);
    add(0, 1, 64'h2000,               64'h2000,               1, 1, 3, 1, 0);
    add(0, 0, 64'h0,                  64'h2004,               0, 1, 3, 1, 0);
    add(0, 0, 64'h0,                  64'h2008,               1, 0, 3, 1, 0);
    add(1, 1, 64'h3003,               64'h3000,               1, 1, 3, 2, 1); // redirect beats stall
    add(1, 0, 64'h0,                  64'h3004,               0, 1, 3, 2, 1); // stall ignored in FLUSH
    add(0, 0, 64'h0,                  64'h3008,               1, 0, 3, 2, 1);
    add(0, 1, 64'h4000,               64'h4000,               1, 1, 3, 3, 1);
    add(0, 1, 64'h5000,               64'h5000,               0, 1, 3, 4, 1); // newest redirect wins
    add(0, 0, 64'h0,                  64'h5004,               0, 1, 3, 4, 1);
    add(0, 0, 64'h0,                  64'h5008,               1, 0, 3, 4, 1);
    add(1, 0, 64'h0,                  64'h5008,               1, 0, 4, 4, 1);
    add(1, 1, 64'h6000,               64'h6000,               1, 1, 4, 5, 1); // redirect out of STALL
    add(0, 0, 64'h0,                  64'h6004,               0, 1, 4, 5, 1);
    add(0, 0, 64'h0,                  64'h6008,               1, 0, 4, 5, 1);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 4, 6, 1);
    add(0, 0, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 4, 6, 1);
    add(0, 0, 64'h0,                  64'h0,                  1, 0, 4, 6, 1); // wrap
    add(0, 0, 64'h0,                  64'h4,                  1, 0, 4, 6, 1);
    add(0, 1, 64'h100,                64'h100,                1, 1, 4, 7, 1);

    @(posedge clk); @(posedge clk); #1;
    chk("reset pc_next",      pc_next, 64'h400);
    chk("reset if_valid",     64'(if_valid), 64'h0);
    chk("reset flush_o",      64'(flush_o), 64'h0);
    chk("reset misalign_o",   64'(misalign_o), 64'h0);
    chk("reset stall_cnt",    64'(stall_cnt), 64'h0);
    chk("reset redirect_cnt", 64'(redirect_cnt), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      stall = vec[i].stall; redirect_valid = vec[i].rv; redirect_target = vec[i].tgt;
      #1;
      chk($sformatf("row%0d pc_next", i),  pc_next, vec[i].pn);
      chk($sformatf("row%0d if_valid", i), 64'(if_valid), 64'(vec[i].ifv));
      chk($sformatf("row%0d flush_o", i),  64'(flush_o), 64'(vec[i].fl));
      @(posedge clk); #1;
      chk($sformatf("row%0d pc_q", i),         pc_q, vec[i].pn);
      chk($sformatf("row%0d stall_cnt", i),    64'(stall_cnt), 64'(vec[i].sc));
      chk($sformatf("row%0d redirect_cnt", i), 64'(redirect_cnt), 64'(vec[i].rc));
      chk($sformatf("row%0d misalign_o", i),   64'(misalign_o), 64'(vec[i].mis));
    end

    // Reset asserted mid-FLUSH.
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; reset = 1'b1;
    #1;
    chk("midflush flush_o before reset", 64'(flush_o), 64'h1);
    @(posedge clk); #1;
    chk("midflush boot pc_next", pc_next, 64'h400);
    chk("midflush if_valid",     64'(if_valid), 64'h0);
    chk("midflush flush_o",      64'(flush_o), 64'h0);
    chk("midflush stall_cnt",    64'(stall_cnt), 64'h0);
    chk("midflush redirect_cnt", 64'(redirect_cnt), 64'h0);
    chk("midflush misalign_o",   64'(misalign_o), 64'h0);
    chk("midflush pc_q",         pc_q, 64'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post reset pc_q",     pc_q, 64'h400);
    chk("post reset if_valid", 64'(if_valid), 64'h1);
    chk("post reset pc_next",  pc_next, 64'h404);

    // Reset asserted mid-STALL.
    @(negedge clk); stall = 1'b1;
    @(posedge clk); #1;
    chk("midstall stall_cnt", 64'(stall_cnt), 64'h1);
    chk("midstall pc_q",      pc_q, 64'h400);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midstall reset stall_cnt", 64'(stall_cnt), 64'h0);
    chk("midstall reset pc_next",   pc_next, 64'h400);
    chk("midstall reset if_valid",  64'(if_valid), 64'h0);
    @(negedge clk); reset = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    chk("midstall recover pc_q", pc_q, 64'h400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
